led_stack_engine: RTL and testbench

//  Parametrised stacking-light sequencer for the TM1638 LED row. A single lit dot drops from bit

---
 rtl/led_stack_if.sv | 24 ++
 rtl/led_stack_engine.sv | 146 ++++++++++++++
 tb/tb_led_stack_engine.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/led_stack_if.sv
// Control/status bundle between the tick divider side and the LED stacking engine.
interface led_stack_if #(
  parameter int unsigned WIDTH = 8
);
  localparam int unsigned LW = $clog2(WIDTH + 1);

  logic             tick;
  logic             restart;
  logic [1:0]       mode;
  logic             mirror;
  logic [WIDTH-1:0] led;
  logic [LW-1:0]    level;
  logic             cycle_done;

  modport master (
    output tick, restart, mode, mirror,
    input  led, level, cycle_done
  );

  modport slave (
    input  tick, restart, mode, mirror,
    output led, level, cycle_done
  );
endinterface

// File: rtl/led_stack_engine.sv
// Stacking-light sequencer: a dot drops onto a growing stack, frames derived from (stack, dot)
// counters, with fill / unstack / ping-pong / freeze modes and a full-frame hold.
module led_stack_engine #(
  parameter int unsigned WIDTH      = 8,
  parameter int unsigned HOLD_TICKS = 0
) (
  input  logic       clk,
  input  logic       reset,
  led_stack_if.slave bus_io
);
  localparam int unsigned IW = $clog2(WIDTH);
  localparam int unsigned LW = $clog2(WIDTH + 1);
  localparam logic [IW-1:0] Top = IW'(WIDTH - 1);
  localparam logic [7:0] HoldMax = 8'(HOLD_TICKS);
  localparam logic [1:0] ModeUnstack = 2'b01;
  localparam logic [1:0] ModePing    = 2'b10;
  localparam logic [1:0] ModeFreeze  = 2'b11;

  typedef enum logic [1:0] {StBlank, StDrop, StHold} state_e;

  state_e           state_q, state_d;
  logic [IW-1:0]    s_q, s_d, p_q, p_d;
  logic             dir_q, dir_d;  // 1: backward
  logic [7:0]       hold_q, hold_d;
  logic [WIDTH-1:0] led_q, led_d;
  logic [LW-1:0]    level_q, level_d;
  logic             done_q, done_d;

  logic             step, rev, full, wrap;
  logic [WIDTH-1:0] one, frame, mapped;

  assign one  = {{(WIDTH-1){1'b0}}, 1'b1};
  assign step = bus_io.tick && (bus_io.mode != ModeFreeze);
  assign rev  = (bus_io.mode == ModeUnstack) || ((bus_io.mode == ModePing) && dir_q);
  assign full = (state_q != StBlank) && (s_q == Top);

  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    p_d     = p_q;
    dir_d   = dir_q;
    hold_d  = hold_q;
    wrap    = 1'b0;
    if (bus_io.restart) begin
      state_d = StBlank;
      s_d     = '0;
      p_d     = '0;
      dir_d   = 1'b0;
      hold_d  = '0;
    end else if (step) begin
      dir_d = rev;
      if (full && (hold_q != HoldMax)) begin
        // Full frame is held for HOLD_TICKS extra ticks whichever way we leave it.
        hold_d  = hold_q + 8'd1;
        state_d = StHold;
      end else begin
        hold_d  = '0;
        state_d = StDrop;
        if (!rev) begin
          if (state_q == StBlank) begin
            s_d = '0;
            p_d = Top;
          end else if (full) begin
            wrap = 1'b1;
            if (bus_io.mode == ModePing) begin
              dir_d = 1'b1;
              s_d   = Top - IW'(1);
              p_d   = Top - IW'(1);
            end else begin
              state_d = StBlank;
              s_d     = '0;
              p_d     = '0;
            end
          end else if (p_q != s_q) begin
            p_d = p_q - IW'(1);
          end else begin
            s_d = s_q + IW'(1);
            p_d = Top;
          end
        end else begin
          if (state_q == StBlank) begin
            wrap = 1'b1;
            if (bus_io.mode == ModePing) begin
              dir_d = 1'b0;
              s_d   = '0;
              p_d   = Top;
            end else begin
              s_d = Top;
              p_d = Top;
            end
          end else if (p_q != Top) begin
            p_d = p_q + IW'(1);
          end else if (s_q != '0) begin
            s_d = s_q - IW'(1);
            p_d = s_q - IW'(1);
          end else begin
            state_d = StBlank;
            s_d     = '0;
            p_d     = '0;
          end
        end
      end
    end
  end

  always_comb begin
    frame = '0;
    if (state_d != StBlank) frame = ((one << s_d) - one) | (one << p_d);
    mapped = frame;
    if (bus_io.mirror) begin
      for (int i = 0; i < WIDTH; i++) mapped[i] = frame[WIDTH-1-i];
    end
    led_d = led_q;
    if (bus_io.restart) led_d = '0;
    else if (step)      led_d = mapped;
    level_d = '0;
    for (int i = 0; i < WIDTH; i++) level_d = level_d + LW'(led_d[i]);
    done_d = !bus_io.restart && step && wrap;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StBlank;
      s_q     <= '0;
      p_q     <= '0;
      dir_q   <= 1'b0;
      hold_q  <= '0;
      led_q   <= '0;
      level_q <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      s_q     <= s_d;
      p_q     <= p_d;
      dir_q   <= dir_d;
      hold_q  <= hold_d;
      led_q   <= led_d;
      level_q <= level_d;
      done_q  <= done_d;
    end
  end

  assign bus_io.led        = led_q;
  assign bus_io.level      = level_q;
  assign bus_io.cycle_done = done_q;
endmodule

// File: tb/tb_led_stack_engine.sv
// Directed bench for led_stack_engine: W=8/H=0, W=8/H=2 and W=4 mirrored instances.
module tb_led_stack_engine;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  led_stack_if #(.WIDTH(8)) if0 ();
  led_stack_if #(.WIDTH(8)) if1 ();
  led_stack_if #(.WIDTH(4)) if2 ();

  led_stack_engine #(.WIDTH(8), .HOLD_TICKS(0)) dut0 (.clk(clk), .reset(reset), .bus_io(if0));
  led_stack_engine #(.WIDTH(8), .HOLD_TICKS(2)) dut1 (.clk(clk), .reset(reset), .bus_io(if1));
  led_stack_engine #(.WIDTH(4), .HOLD_TICKS(0)) dut2 (.clk(clk), .reset(reset), .bus_io(if2));

  typedef struct {
    logic       tick;
    logic       restart;
    logic [1:0] mode;
    logic [7:0] led;
    logic       cd;
  } vec_t;

  vec_t       tab0[10];
  logic [7:0] tab2[11];
  logic [7:0] fr[37];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick0(input logic [1:0] m);
    if0.mode = m;
    if0.tick = 1'b1;
    @(posedge clk);
    #1;
    if0.tick = 1'b0;
  endtask

  task automatic tick1(input logic [1:0] m);
    if1.mode = m;
    if1.tick = 1'b1;
    @(posedge clk);
    #1;
    if1.tick = 1'b0;
  endtask

  task automatic tick2(input logic [1:0] m);
    if2.mode = m;
    if2.tick = 1'b1;
    @(posedge clk);
    #1;
    if2.tick = 1'b0;
  endtask

  task automatic restart0();
    if0.restart = 1'b1;
    @(posedge clk);
    #1;
    if0.restart = 1'b0;
  endtask

  initial begin
    int idx;
    logic [7:0] lo;

    tab0[0] = '{1'b1, 1'b0, 2'd1, 8'hFF, 1'b1};
    tab0[1] = '{1'b1, 1'b0, 2'd1, 8'h7F, 1'b0};
    tab0[2] = '{1'b1, 1'b0, 2'd1, 8'hBF, 1'b0};
    tab0[3] = '{1'b1, 1'b0, 2'd1, 8'h3F, 1'b0};
    tab0[4] = '{1'b1, 1'b0, 2'd0, 8'hBF, 1'b0};
    tab0[5] = '{1'b0, 1'b0, 2'd0, 8'hBF, 1'b0};
    tab0[6] = '{1'b1, 1'b0, 2'd3, 8'hBF, 1'b0};
    tab0[7] = '{1'b1, 1'b1, 2'd0, 8'h00, 1'b0};
    tab0[8] = '{1'b1, 1'b0, 2'd0, 8'h80, 1'b0};
    tab0[9] = '{1'b1, 1'b0, 2'd2, 8'h40, 1'b0};
    tab2 = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h09, 8'h0A, 8'h0C, 8'h0D, 8'h0E, 8'h0F, 8'h00};

    // Reference frame list straight from the (s,p) definition.
    fr[0] = 8'h00;
    idx = 1;
    for (int s = 0; s < 8; s++) begin
      lo = (8'd1 << s) - 8'd1;
      for (int p = 7; p >= s; p--) begin
        fr[idx] = lo | (8'd1 << p);
        idx++;
      end
    end

    if0.tick = 0; if0.restart = 0; if0.mode = 0; if0.mirror = 0;
    if1.tick = 0; if1.restart = 0; if1.mode = 0; if1.mirror = 0;
    if2.tick = 0; if2.restart = 0; if2.mode = 0; if2.mirror = 1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;

    chk("reset_led", if0.led, 0);
    chk("reset_level", if0.level, 0);
    chk("reset_cd", if0.cycle_done, 0);
    chk("reset_led_w4", if2.led, 0);

    // Fill, W=8, H=0
    for (int t = 1; t <= 37; t++) begin
      tick0(2'd0);
      chk("fill_led", if0.led, (t == 37) ? 8'h00 : fr[t]);
      chk("fill_cd", if0.cycle_done, (t == 37) ? 1 : 0);
      if (t == 36) chk("fill_level_full", if0.level, 8);
    end

    // Fill, W=8, H=2
    for (int t = 1; t <= 39; t++) begin
      tick1(2'd0);
      if (t >= 36) begin
        chk("hold_led", if1.led, (t == 39) ? 8'h00 : 8'hFF);
        chk("hold_level", if1.level, (t == 39) ? 0 : 8);
        chk("hold_cd", if1.cycle_done, (t == 39) ? 1 : 0);
      end
    end

    // Ping-pong from blank
    for (int t = 1; t <= 73; t++) begin
      tick0(2'd2);
      chk("pp_cd", if0.cycle_done, (t == 37 || t == 73) ? 1 : 0);
      if (t == 36) chk("pp_led36", if0.led, 8'hFF);
      if (t == 37) chk("pp_led37", if0.led, 8'h7F);
      if (t == 72) chk("pp_led72", if0.led, 8'h00);
      if (t == 73) chk("pp_led73", if0.led, 8'h80);
    end

    // Unstack and mode-switch table
    restart0();
    chk("restart_led", if0.led, 0);
    for (int i = 0; i < 10; i++) begin
      if0.tick = tab0[i].tick;
      if0.restart = tab0[i].restart;
      if0.mode = tab0[i].mode;
      @(posedge clk);
      #1;
      if0.tick = 1'b0;
      if0.restart = 1'b0;
      chk($sformatf("tab0_led[%0d]", i), if0.led, tab0[i].led);
      chk($sformatf("tab0_cd[%0d]", i), if0.cycle_done, tab0[i].cd);
    end

    // Freeze at 0x13
    restart0();
    for (int t = 1; t <= 19; t++) tick0(2'd0);
    chk("frz_reach", if0.led, 8'h13);
    for (int t = 0; t < 10; t++) begin
      tick0(2'd3);
      chk("frz_led", if0.led, 8'h13);
      chk("frz_cd", if0.cycle_done, 0);
    end
    chk("frz_level", if0.level, 3);
    if0.restart = 1'b1;
    tick0(2'd0);
    if0.restart = 1'b0;
    chk("restart_tick_led", if0.led, 0);
    chk("restart_tick_cd", if0.cycle_done, 0);
    tick0(2'd0);
    chk("after_restart", if0.led, 8'h80);

    // W=4 mirrored fill
    for (int i = 0; i < 11; i++) begin
      tick2(2'd0);
      chk($sformatf("mirror_led[%0d]", i), if2.led, tab2[i]);
      chk($sformatf("mirror_cd[%0d]", i), if2.cycle_done, (i == 10) ? 1 : 0);
    end

    // Async reset mid-hold
    for (int t = 1; t <= 37; t++) tick1(2'd0);
    chk("prehold_led", if1.led, 8'hFF);
    @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    chk("async_led", if1.led, 0);
    chk("async_level", if1.level, 0);
    chk("async_led_dut0", if0.led, 0);
    @(negedge clk);
    reset = 1'b0;
    tick1(2'd0);
    chk("post_reset_led", if1.led, 8'h80);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
